// File: rtl/pid_pkg.sv
// pid_pkg: shared types, default widths and the saturation helper for the
// time-multiplexed PID controller.
//   pid_state_t : sequencer states (idle, three multiply slots, sum/writeback)
//   sat_dir_t   : per-channel direction of the last output saturation
//   sat_s       : symmetric clip of a signed value to +/-(2^(width-1)-1)
package pid_pkg;

    localparam int DEF_DW = 10;
    localparam int DEF_KW = 4;
    localparam int DEF_IW = 16;
    localparam int DEF_OW = 15;
    localparam int DEF_CH = 4;

    // Derived widths for the default configuration: error, error delta,
    // product (unsigned gain widened by one sign bit) and full-precision sum.
    localparam int EW  = DEF_DW + 1;
    localparam int DIW = DEF_DW + 2;
    localparam int PW  = DEF_IW + DEF_KW + 1;
    localparam int SW  = PW + 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MUL_P = 3'd1,
        ST_MUL_I = 3'd2,
        ST_MUL_D = 3'd3,
        ST_SUM   = 3'd4
    } pid_state_t;

    typedef enum logic [1:0] {
        SAT_NONE = 2'd0,
        SAT_POS  = 2'd1,
        SAT_NEG  = 2'd2
    } sat_dir_t;

    // Symmetric limit: the most negative code is never produced.
    function automatic logic signed [63:0] sat_s(input logic signed [63:0] val,
                                                 input int width);
        logic signed [63:0] lim;
        lim = (64'sd1 <<< (width - 1)) - 64'sd1;
        if (val > lim) begin
            sat_s = lim;
        end else if (val < -lim) begin
            sat_s = -lim;
        end else begin
            sat_s = val;
        end
    endfunction

endpackage

// File: rtl/pid_ctrl_mc_sat.sv
// pid_sat: combinational signed saturator, IN_W bits in, OUT_W bits out,
// symmetric range +/-(2^(OUT_W-1)-1).
//   in_val  : signed input value
//   out_val : clipped value
//   clipped : 1 when out_val differs from in_val
module pid_sat
    import pid_pkg::*;
#(
    parameter int IN_W  = 17,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  in_val,
    output logic signed [OUT_W-1:0] out_val,
    output logic                    clipped
);

    logic signed [63:0] ext_s;
    logic signed [63:0] lim_s;

    // Sign-extend, clip, and flag whether clipping changed the value.
    always_comb begin
        ext_s   = 64'(in_val);
        lim_s   = sat_s(ext_s, OUT_W);
        out_val = lim_s[OUT_W-1:0];
        clipped = (lim_s != ext_s);
    end

endmodule

// File: rtl/pid_ctrl_mc.sv
// pid_ctrl_mc: CH-channel positional PID controller sharing one multiplier.
// A sample is accepted in IDLE; P, I and D products are formed in three
// consecutive cycles and the saturated sum is registered in the fourth.
//   clk, rst            : clock, synchronous active-high reset
//   start, ch           : sample valid and its channel (taken when ready)
//   target, y           : signed set point and measurement
//   kp, ki, kd          : unsigned gains, latched with the sample
//   clr, clr_ch         : clear integrator/e_prev/sat_dir of one channel
//   ready               : idle, sample can be accepted
//   out_valid           : one-cycle result strobe
//   out_ch, uk, sat     : result channel, saturated output, clip flag
module pid_ctrl_mc
    import pid_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int KW = DEF_KW,
    parameter int IW = DEF_IW,
    parameter int OW = DEF_OW,
    parameter int CH = DEF_CH,
    localparam int CW = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CW-1:0]        ch,
    input  logic signed [DW-1:0] target,
    input  logic signed [DW-1:0] y,
    input  logic [KW-1:0]        kp,
    input  logic [KW-1:0]        ki,
    input  logic [KW-1:0]        kd,
    input  logic                 clr,
    input  logic [CW-1:0]        clr_ch,
    output logic                 ready,
    output logic                 out_valid,
    output logic [CW-1:0]        out_ch,
    output logic signed [OW-1:0] uk,
    output logic                 sat
);

    localparam int E_W  = DW + 1;
    localparam int DI_W = DW + 2;
    localparam int OP_W = (IW > DI_W) ? IW : DI_W;
    localparam int P_W  = OP_W + KW + 1;
    localparam int S_W  = P_W + 2;

    pid_state_t           state_r;
    logic [CW-1:0]        ch_r;
    logic [KW-1:0]        kp_r, ki_r, kd_r;
    logic signed [E_W-1:0] e_r;
    logic signed [P_W-1:0] p_r, i_r, d_r;
    logic signed [IW-1:0] integ_n_r;

    logic signed [IW-1:0]  integ_r   [CH];
    logic signed [E_W-1:0] e_prev_r  [CH];
    sat_dir_t              sat_dir_r [CH];

    logic                  ch_ok_s;
    logic [KW-1:0]         mul_gain_s;
    logic signed [OP_W-1:0] mul_opnd_s;
    logic signed [P_W-1:0] mul_prod_s;
    logic signed [IW:0]    integ_sum_s;
    logic signed [IW-1:0]  integ_clip_s;
    logic                  integ_clipped_s;
    logic                  freeze_s;
    logic signed [IW-1:0]  integ_n_s;
    logic signed [DI_W-1:0] de_s;
    logic signed [S_W-1:0] sum_s;
    logic signed [OW-1:0]  uk_s;
    logic                  uk_clip_s;
    sat_dir_t              dir_s;

    // Out-of-range channel indices can only exist when CH is not a power of two.
    generate
        if (CH == (1 << CW)) begin : g_ch_full
            assign ch_ok_s = 1'b1;
        end else begin : g_ch_part
            assign ch_ok_s = ({1'b0, ch} < (CW + 1)'(CH));
        end
    endgenerate

    // Integrator candidate: clamp(integ+e), held when the last output was
    // saturated in the same direction as the current error (anti-windup).
    always_comb begin
        integ_sum_s = (IW + 1)'(integ_r[ch_r]) + (IW + 1)'(e_r);
        if (sat_dir_r[ch_r] == SAT_POS) begin
            freeze_s = !e_r[E_W-1] && (e_r != '0);
        end else if (sat_dir_r[ch_r] == SAT_NEG) begin
            freeze_s = e_r[E_W-1];
        end else begin
            freeze_s = 1'b0;
        end
        if (freeze_s) begin
            integ_n_s = integ_r[ch_r];
        end else begin
            integ_n_s = integ_clip_s;
        end
        de_s = DI_W'(e_r) - DI_W'(e_prev_r[ch_r]);
    end

    pid_sat #(.IN_W(IW + 1), .OUT_W(IW)) u_integ_sat (
        .in_val  (integ_sum_s),
        .out_val (integ_clip_s),
        .clipped (integ_clipped_s)
    );

    // Shared multiplier operand select, one product per MUL_* state.
    always_comb begin
        mul_gain_s = '0;
        mul_opnd_s = '0;
        case (state_r)
            ST_MUL_P: begin
                mul_gain_s = kp_r;
                mul_opnd_s = OP_W'(e_r);
            end
            ST_MUL_I: begin
                mul_gain_s = ki_r;
                mul_opnd_s = OP_W'(integ_n_s);
            end
            ST_MUL_D: begin
                mul_gain_s = kd_r;
                mul_opnd_s = OP_W'(de_s);
            end
            default: begin
                mul_gain_s = '0;
                mul_opnd_s = '0;
            end
        endcase
        mul_prod_s = P_W'($signed({1'b0, mul_gain_s})) * P_W'(mul_opnd_s);
    end

    // Full-width sum (cannot overflow) and its saturation direction.
    always_comb begin
        sum_s = S_W'(p_r) + S_W'(i_r) + S_W'(d_r);
        if (!uk_clip_s) begin
            dir_s = SAT_NONE;
        end else if (sum_s[S_W-1]) begin
            dir_s = SAT_NEG;
        end else begin
            dir_s = SAT_POS;
        end
    end

    pid_sat #(.IN_W(S_W), .OUT_W(OW)) u_out_sat (
        .in_val  (sum_s),
        .out_val (uk_s),
        .clipped (uk_clip_s)
    );

    // Sequencer: accept, three multiply slots, then register the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            ready     <= 1'b1;
            out_valid <= 1'b0;
            out_ch    <= '0;
            uk        <= '0;
            sat       <= 1'b0;
            ch_r      <= '0;
            kp_r      <= '0;
            ki_r      <= '0;
            kd_r      <= '0;
            e_r       <= '0;
            p_r       <= '0;
            i_r       <= '0;
            d_r       <= '0;
            integ_n_r <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start && ch_ok_s) begin
                        ch_r    <= ch;
                        kp_r    <= kp;
                        ki_r    <= ki;
                        kd_r    <= kd;
                        e_r     <= E_W'(target) - E_W'(y);
                        ready   <= 1'b0;
                        state_r <= ST_MUL_P;
                    end
                end
                ST_MUL_P: begin
                    p_r     <= mul_prod_s;
                    state_r <= ST_MUL_I;
                end
                ST_MUL_I: begin
                    i_r       <= mul_prod_s;
                    integ_n_r <= integ_n_s;
                    state_r   <= ST_MUL_D;
                end
                ST_MUL_D: begin
                    d_r     <= mul_prod_s;
                    state_r <= ST_SUM;
                end
                ST_SUM: begin
                    uk        <= uk_s;
                    sat       <= uk_clip_s;
                    out_ch    <= ch_r;
                    out_valid <= 1'b1;
                    ready     <= 1'b1;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    ready   <= 1'b1;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Per-channel state: a clear on the same edge overrides the writeback.
    always_ff @(posedge clk) begin
        for (int i = 0; i < CH; i++) begin
            if (rst || (clr && (clr_ch == CW'(i)))) begin
                integ_r[i]   <= '0;
                e_prev_r[i]  <= '0;
                sat_dir_r[i] <= SAT_NONE;
            end else if ((state_r == ST_SUM) && (ch_r == CW'(i))) begin
                integ_r[i]   <= integ_n_r;
                e_prev_r[i]  <= e_r;
                sat_dir_r[i] <= dir_s;
            end
        end
    end

endmodule

// File: tb/tb_pid_ctrl_mc.sv
module tb_pid_ctrl_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, start, clr;
    logic [1:0]        ch, clr_ch, out_ch;
    logic signed [9:0] target, y;
    logic [3:0]        kp, ki, kd;
    logic              ready, out_valid, sat;
    logic signed [14:0] uk;

    int checks = 0;
    int errors = 0;

    // Result of the most recent do_op call.
    bit                 got;
    bit                 busy_ok;
    int                 lat;
    logic signed [14:0] r_uk;
    logic               r_sat;
    logic [1:0]         r_ch;

    pid_ctrl_mc #(.DW(10), .KW(4), .IW(16), .OW(15), .CH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ch        (ch),
        .target    (target),
        .y         (y),
        .kp        (kp),
        .ki        (ki),
        .kd        (kd),
        .clr       (clr),
        .clr_ch    (clr_ch),
        .ready     (ready),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .uk        (uk),
        .sat       (sat)
    );

    // Issue one sample and wait (max 8 cycles) for out_valid.
    // clr_k / rst_k: pulse clr / rst on edge T+k (-1 = never, 0 = accept edge).
    // poke: keep start high with a ch0 sample on edges T+1..T+3.
    task automatic do_op(input logic [1:0] c, input int t, input int yv,
                         input int kpv, input int kiv, input int kdv,
                         input int clr_k, input logic [1:0] clr_c,
                         input int rst_k, input bit poke);
        ch = c; target = t[9:0]; y = yv[9:0];
        kp = kpv[3:0]; ki = kiv[3:0]; kd = kdv[3:0];
        start = 1'b1;
        clr = (clr_k == 0); clr_ch = clr_c;
        @(posedge clk); #1;
        start = 1'b0; clr = 1'b0;
        got = 1'b0; busy_ok = 1'b1; lat = 0;
        for (int k = 1; k <= 8 && !got; k++) begin
            if (poke && k <= 3) begin
                start = 1'b1; ch = 2'd0; target = 10'sd350; y = 10'sd0;
            end else begin
                start = 1'b0;
            end
            clr = (clr_k == k);
            rst = (rst_k == k);
            @(posedge clk); #1;
            clr = 1'b0; rst = 1'b0;
            if (out_valid === 1'b1) begin
                got = 1'b1; lat = k; r_uk = uk; r_sat = sat; r_ch = out_ch;
            end else if (k < 4 && (rst_k < 0 || k < rst_k) && ready !== 1'b0) begin
                busy_ok = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    task automatic clear_ch(input logic [1:0] c);
        clr = 1'b1; clr_ch = c;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; clr = 1'b0; ch = '0; clr_ch = '0;
        target = '0; y = '0; kp = '0; ki = '0; kd = '0;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (uk !== 15'sd0 || sat !== 1'b0 || out_ch !== 2'd0)
            begin errors++; $display("FAIL reset_outputs got uk=%0d sat=%b ch=%0d want 0 0 0", uk, sat, out_ch); end
    endtask

    task automatic test_basic();
        do_op(2'd0, 350, 0, 10, 9, 8, -1, 2'd0, -1, 1'b0);
        checks++; if (!got || lat != 4) begin errors++; $display("FAIL basic_latency got %0d (seen=%0b) want 4", lat, got); end
        checks++; if (!busy_ok) begin errors++; $display("FAIL basic_ready_busy got ready=1 while busy want 0"); end
        checks++; if (r_uk !== 15'sd9450 || r_sat !== 1'b0 || r_ch !== 2'd0)
            begin errors++; $display("FAIL basic_uk1 got %0d sat=%b ch=%0d want 9450 0 0", r_uk, r_sat, r_ch); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || uk !== 15'sd9450 || ready !== 1'b1)
            begin errors++; $display("FAIL basic_hold got valid=%b uk=%0d ready=%b want 0 9450 1", out_valid, uk, ready); end
        do_op(2'd0, 350, 100, 10, 9, 8, -1, 2'd0, -1, 1'b0);
        checks++; if (!got || r_uk !== 15'sd7100 || r_sat !== 1'b0)
            begin errors++; $display("FAIL basic_uk2 got %0d sat=%b want 7100 0", r_uk, r_sat); end
    endtask

    task automatic test_saturation();
        clear_ch(2'd0);
        do_op(2'd0, 511, -512, 15, 15, 15, -1, 2'd0, -1, 1'b0);
        checks++; if (!got || r_uk !== 15'sd16383 || r_sat !== 1'b1)
            begin errors++; $display("FAIL sat_pos1 got %0d sat=%b want 16383 1", r_uk, r_sat); end
        do_op(2'd0, 511, -512, 15, 15, 15, -1, 2'd0, -1, 1'b0);
        checks++; if (!got || r_uk !== 15'sd16383 || r_sat !== 1'b1)
            begin errors++; $display("FAIL sat_pos2 got %0d sat=%b want 16383 1", r_uk, r_sat); end
        // Integrator must still be 1023 (frozen); e=-1 unfreezes -> 1022.
        do_op(2'd0, 0, 1, 0, 1, 0, -1, 2'd0, -1, 1'b0);
        checks++; if (!got || r_uk !== 15'sd1022 || r_sat !== 1'b0)
            begin errors++; $display("FAIL sat_frozen_integ got %0d sat=%b want 1022 0", r_uk, r_sat); end
        do_op(2'd2, -512, 511, 15, 15, 15, -1, 2'd0, -1, 1'b0);
        checks++; if (!got || r_uk !== -15'sd16383 || r_sat !== 1'b1 || r_ch !== 2'd2)
            begin errors++; $display("FAIL sat_neg got %0d sat=%b ch=%0d want -16383 1 2", r_uk, r_sat, r_ch); end
    endtask

    task automatic test_interleave();
        clear_ch(2'd0);
        clear_ch(2'd1);
        do_op(2'd1, -200, 0, 10, 9, 8, -1, 2'd0, -1, 1'b0);
        checks++; if (!got || r_uk !== -15'sd5400 || r_ch !== 2'd1)
            begin errors++; $display("FAIL ilv_ch1_a got %0d ch=%0d want -5400 1", r_uk, r_ch); end
        do_op(2'd0, 350, 0, 10, 9, 8, -1, 2'd0, -1, 1'b0);
        checks++; if (!got || r_uk !== 15'sd9450 || r_ch !== 2'd0)
            begin errors++; $display("FAIL ilv_ch0_a got %0d ch=%0d want 9450 0", r_uk, r_ch); end
        do_op(2'd1, -200, 0, 10, 9, 8, -1, 2'd0, -1, 1'b0);
        checks++; if (!got || r_uk !== -15'sd5600)
            begin errors++; $display("FAIL ilv_ch1_b got %0d want -5600", r_uk); end
        do_op(2'd0, 350, 100, 10, 9, 8, -1, 2'd0, -1, 1'b0);
        checks++; if (!got || r_uk !== 15'sd7100)
            begin errors++; $display("FAIL ilv_ch0_b got %0d want 7100", r_uk); end
    endtask

    task automatic test_busy_and_clr();
        int extra;
        do_op(2'd3, 10, 0, 10, 9, 8, -1, 2'd0, -1, 1'b1);
        checks++; if (!got || lat != 4 || r_uk !== 15'sd270 || r_ch !== 2'd3)
            begin errors++; $display("FAIL busy_op got %0d ch=%0d lat=%0d want 270 3 4", r_uk, r_ch, lat); end
        extra = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL busy_ignored got %0d extra results want 0", extra); end
        clear_ch(2'd0);
        do_op(2'd0, 350, 0, 10, 9, 8, -1, 2'd0, -1, 1'b0);
        checks++; if (!got || r_uk !== 15'sd9450)
            begin errors++; $display("FAIL clr_then_op got %0d want 9450", r_uk); end
    endtask

    task automatic test_clr_same_cycle();
        do_op(2'd0, 350, 0, 10, 9, 8, 0, 2'd0, -1, 1'b0);
        checks++; if (!got || r_uk !== 15'sd9450)
            begin errors++; $display("FAIL clr_same_cycle got %0d want 9450", r_uk); end
    endtask

    task automatic test_clr_in_flight();
        do_op(2'd0, 350, 100, 10, 9, 8, 4, 2'd0, -1, 1'b0);
        checks++; if (!got || r_uk !== 15'sd7100)
            begin errors++; $display("FAIL clr_inflight_out got %0d want 7100", r_uk); end
        do_op(2'd0, 350, 0, 10, 9, 8, -1, 2'd0, -1, 1'b0);
        checks++; if (!got || r_uk !== 15'sd9450)
            begin errors++; $display("FAIL clr_inflight_after got %0d want 9450", r_uk); end
    endtask

    task automatic test_rst_mid_op();
        do_op(2'd0, 350, 0, 10, 9, 8, -1, 2'd0, 2, 1'b0);
        checks++; if (got) begin errors++; $display("FAIL rst_abort got out_valid want none"); end
        checks++; if (uk !== 15'sd0 || ready !== 1'b1 || sat !== 1'b0)
            begin errors++; $display("FAIL rst_state got uk=%0d ready=%b sat=%b want 0 1 0", uk, ready, sat); end
        do_op(2'd0, 350, 0, 10, 9, 8, -1, 2'd0, -1, 1'b0);
        checks++; if (!got || r_uk !== 15'sd9450)
            begin errors++; $display("FAIL rst_then_op got %0d want 9450", r_uk); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_interleave();
        test_busy_and_clr();
        test_clr_same_cycle();
        test_clr_in_flight();
        test_rst_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
